mips_retire_checker: RTL and testbench

MIPS_RETIRE_CHECKER -- requirements
Module: mips_retire_checker

---
 rtl/mips_retire_checker_pkg.sv | 34 +++
 rtl/mips_ref_alu.sv | 32 +++
 rtl/mips_retire_checker.sv | 128 ++++++++++++
 tb/tb_mips_retire_checker.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_retire_checker_pkg.sv
// mips_retire_checker_pkg
// Shared definitions for the MIPS retire checker: FSM state encoding,
// opcode/funct constants of the checked R-type ALU instructions, and the
// bit positions of the instruction fields used by the checker.
package mips_retire_checker_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        WAIT,
        COMPARE
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam int unsigned OP_HI = 31;
    localparam int unsigned OP_LO = 26;
    localparam int unsigned RS_HI = 25;
    localparam int unsigned RS_LO = 21;
    localparam int unsigned RT_HI = 20;
    localparam int unsigned RT_LO = 16;
    localparam int unsigned RD_HI = 15;
    localparam int unsigned RD_LO = 11;
    localparam int unsigned SH_HI = 10;
    localparam int unsigned SH_LO = 6;
    localparam int unsigned FN_HI = 5;
    localparam int unsigned FN_LO = 0;

endpackage

// File: rtl/mips_ref_alu.sv
// mips_ref_alu
// Combinational reference ALU producing the value an R-type instruction
// should have written.
// Ports:
//   funct     in  6   R-type function field
//   a, b      in  32  rs / rt operand values
//   result    out 32  expected result (32-bit wrap for ADD/SUB)
//   supported out 1   funct is one of ADD/SUB/AND/OR/SLT
module mips_ref_alu
    import mips_retire_checker_pkg::*;
(
    input  logic [5:0]  funct,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        supported
);

    always_comb begin
        result    = '0;
        supported = 1'b1;
        case (funct)
            FN_ADD:  result = a + b;
            FN_SUB:  result = a - b;
            FN_AND:  result = a & b;
            FN_OR:   result = a | b;
            FN_SLT:  result = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
            default: supported = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_retire_checker.sv
// mips_retire_checker
// Checks retired R-type ALU instructions: requests rs/rt operands from a
// CPU-side responder, waits RESP_LAT cycles, then compares the written rd
// value against a reference ALU and keeps saturating statistics.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   retire_valid/instr  in   retired instruction (accepted while ready=1)
//   ready               out  checker idle, can accept a retire
//   rs, rt              out  register indices sent to the responder
//   rs/rt/rd_value, pc  in   responder data, valid RESP_LAT cycles after rs/rt
//   err                 out  one-cycle pulse on a mismatch
//   err_pc              out  pc of the last mismatch
//   check/err/skip_count out saturating statistics counters
module mips_retire_checker
    import mips_retire_checker_pkg::*;
#(
    parameter int unsigned RESP_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             retire_valid,
    input  logic [31:0]      retire_instr,
    output logic             ready,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    input  logic [31:0]      rs_value,
    input  logic [31:0]      rt_value,
    input  logic [31:0]      rd_value,
    input  logic [31:0]      pc,
    output logic             err,
    output logic [31:0]      err_pc,
    output logic [CNT_W-1:0] check_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] skip_count
);

    state_t      state, state_next;
    logic [5:0]  opcode_q;
    logic [5:0]  funct_q;
    logic [4:0]  rd_q;
    logic [1:0]  lat_cnt;
    logic [31:0] alu_result;
    logic [31:0] expected;
    logic        alu_supported;
    logic        checked;
    logic        mismatch;
    logic        unused_shamt;

    // shamt plays no part in the checked instructions
    assign unused_shamt = ^retire_instr[SH_HI:SH_LO];

    mips_ref_alu u_ref_alu (
        .funct     (funct_q),
        .a         (rs_value),
        .b         (rt_value),
        .result    (alu_result),
        .supported (alu_supported)
    );

    assign ready = (state == IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (retire_valid) state_next = ADDR;
            ADDR:    state_next = (RESP_LAT <= 1) ? COMPARE : WAIT;
            // leave on the cycle the counter would reach zero so that the
            // total accept-to-update latency is RESP_LAT+1
            WAIT:    if (lat_cnt <= 2'd1) state_next = COMPARE;
            COMPARE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        checked  = (opcode_q == OP_RTYPE) && alu_supported;
        expected = (rd_q == '0) ? '0 : alu_result;
        mismatch = checked && (rd_value != expected);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            opcode_q    <= '0;
            funct_q     <= '0;
            rd_q        <= '0;
            lat_cnt     <= '0;
            rs          <= '0;
            rt          <= '0;
            err         <= 1'b0;
            err_pc      <= '0;
            check_count <= '0;
            err_count   <= '0;
            skip_count  <= '0;
        end else begin
            state <= state_next;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (retire_valid) begin
                        opcode_q <= retire_instr[OP_HI:OP_LO];
                        funct_q  <= retire_instr[FN_HI:FN_LO];
                        rd_q     <= retire_instr[RD_HI:RD_LO];
                        rs       <= retire_instr[RS_HI:RS_LO];
                        rt       <= retire_instr[RT_HI:RT_LO];
                    end
                end
                ADDR: lat_cnt <= 2'(RESP_LAT - 1);
                WAIT: lat_cnt <= lat_cnt - 2'd1;
                COMPARE: begin
                    if (!checked) begin
                        if (skip_count != '1) skip_count <= skip_count + 1'b1;
                    end else begin
                        if (check_count != '1) check_count <= check_count + 1'b1;
                        if (mismatch) begin
                            if (err_count != '1) err_count <= err_count + 1'b1;
                            err    <= 1'b1;
                            err_pc <= pc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_retire_checker.sv
// tb_mips_retire_checker
// Scoreboard bench: dut_a (RESP_LAT=1, CNT_W=16) takes directed and random
// retires whose expected outcomes are queued and popped by a monitor on each
// counter update; dut_b (RESP_LAT=3, CNT_W=4) covers latency, mid-check
// reset and counter saturation.
module tb_mips_retire_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // responder register file shared by both DUTs (used one at a time)
    logic [31:0] regs [32];

    // ---------------- DUT A ----------------
    logic        a_rst = 1'b1, a_rv = 1'b0, a_ready, a_err;
    logic [31:0] a_instr = '0, a_rs_value, a_rt_value, a_rd_value = '0, a_pc = '0, a_err_pc;
    logic [4:0]  a_rs, a_rt, a_rs_d, a_rt_d;
    logic [15:0] a_chk, a_errc, a_skip;

    mips_retire_checker #(.RESP_LAT(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(a_rst), .retire_valid(a_rv), .retire_instr(a_instr),
        .ready(a_ready), .rs(a_rs), .rt(a_rt),
        .rs_value(a_rs_value), .rt_value(a_rt_value), .rd_value(a_rd_value), .pc(a_pc),
        .err(a_err), .err_pc(a_err_pc),
        .check_count(a_chk), .err_count(a_errc), .skip_count(a_skip)
    );

    always @(posedge clk) begin
        a_rs_d <= a_rs;
        a_rt_d <= a_rt;
    end
    assign a_rs_value = regs[a_rs_d];
    assign a_rt_value = regs[a_rt_d];

    // ---------------- DUT B ----------------
    logic        b_rst = 1'b1, b_rv = 1'b0, b_ready, b_err;
    logic [31:0] b_instr = '0, b_rs_value, b_rt_value, b_rd_value = '0, b_pc = '0, b_err_pc;
    logic [4:0]  b_rs, b_rt;
    logic [4:0]  b_rs_p [3];
    logic [4:0]  b_rt_p [3];
    logic [3:0]  b_chk, b_errc, b_skip;
    int          b_err_pulses = 0;

    mips_retire_checker #(.RESP_LAT(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst(b_rst), .retire_valid(b_rv), .retire_instr(b_instr),
        .ready(b_ready), .rs(b_rs), .rt(b_rt),
        .rs_value(b_rs_value), .rt_value(b_rt_value), .rd_value(b_rd_value), .pc(b_pc),
        .err(b_err), .err_pc(b_err_pc),
        .check_count(b_chk), .err_count(b_errc), .skip_count(b_skip)
    );

    always @(posedge clk) begin
        b_rs_p[0] <= b_rs;  b_rs_p[1] <= b_rs_p[0]; b_rs_p[2] <= b_rs_p[1];
        b_rt_p[0] <= b_rt;  b_rt_p[1] <= b_rt_p[0]; b_rt_p[2] <= b_rt_p[1];
    end
    assign b_rs_value = regs[b_rs_p[2]];
    assign b_rt_value = regs[b_rt_p[2]];

    always @(negedge clk) if (b_err === 1'b1) b_err_pulses++;

    // ---------------- reference model ----------------
    function automatic logic [31:0] mk_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        logic [4:0] s, t, d;
        s = 5'(rs); t = 5'(rt); d = 5'(rd);
        return {6'h00, s, t, d, 5'h00, fn};
    endfunction

    // returns {supported, expected rd value}
    function automatic logic [32:0] ref_eval(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
        logic [5:0]  op, fn;
        logic [31:0] v;
        logic        sup;
        op  = instr[31:26];
        fn  = instr[5:0];
        sup = (op == 6'h00);
        v   = 32'h0;
        case (fn)
            6'h20: v = 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
            6'h22: v = 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
            6'h24: v = a & b;
            6'h25: v = a | b;
            6'h2A: v = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: sup = 1'b0;
        endcase
        if (instr[15:11] == 5'd0) v = 32'h0;
        return {sup, v};
    endfunction

    typedef struct {
        logic        is_skip;
        logic        is_err;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   exp_chk = 0, exp_err = 0, exp_skip = 0;

    // ---------------- monitor for DUT A ----------------
    logic        mon_en = 1'b0;
    logic [15:0] p_chk, p_errc, p_skip;
    exp_t        m_e;

    always @(negedge clk) begin
        if (a_rst || !mon_en) begin
            p_chk = a_chk; p_errc = a_errc; p_skip = a_skip;
        end else begin
            if (a_chk != p_chk || a_skip != p_skip) begin
                if (exp_q.size() == 0) begin
                    check("a_unexpected_update", 1, 0);
                end else begin
                    m_e = exp_q.pop_front();
                    check("a_chk_delta",  64'(a_chk - p_chk),   m_e.is_skip ? 0 : 1);
                    check("a_skip_delta", 64'(a_skip - p_skip), m_e.is_skip ? 1 : 0);
                    check("a_errc_delta", 64'(a_errc - p_errc), m_e.is_err ? 1 : 0);
                    check("a_err_pulse",  a_err, m_e.is_err);
                    if (m_e.is_err) check("a_err_pc", a_err_pc, m_e.pc);
                end
            end else if (a_err !== 1'b0) begin
                check("a_stray_err", a_err, 0);
            end
            p_chk = a_chk; p_errc = a_errc; p_skip = a_skip;
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic issue_a(input logic [31:0] instr, input logic [31:0] va, input logic [31:0] vb,
                           input logic use_model, input logic [31:0] rd_custom,
                           input logic [31:0] pcv, input int hold);
        int          n;
        logic [32:0] r;
        logic [31:0] rdv;
        exp_t        e;
        n = 0;
        while (!a_ready) begin
            @(posedge clk); #1; n++;
            if (n > 50) begin fail_now("a_ready_timeout"); break; end
        end
        regs[instr[25:21]] = va;
        regs[instr[20:16]] = vb;
        r   = ref_eval(instr, regs[instr[25:21]], regs[instr[20:16]]);
        rdv = use_model ? r[31:0] : rd_custom;
        e.is_skip = !r[32];
        e.is_err  = r[32] && (rdv != r[31:0]);
        e.pc      = pcv;
        exp_q.push_back(e);
        if (e.is_skip) exp_skip++; else exp_chk++;
        if (e.is_err) exp_err++;
        a_rd_value = rdv; a_pc = pcv; a_instr = instr; a_rv = 1'b1;
        @(posedge clk); #1;
        check("a_busy_after_accept", a_ready, 0);
        repeat (hold) begin @(posedge clk); #1; end
        a_rv = 1'b0;
    endtask

    task automatic drain_a();
        int n;
        n = 0;
        while (exp_q.size() != 0 || !a_ready) begin
            @(posedge clk); #1; n++;
            if (n > 50) begin fail_now("a_drain_timeout"); break; end
        end
    endtask

    task automatic issue_b(input logic [31:0] instr, input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] rdv, input logic [31:0] pcv);
        int n;
        n = 0;
        while (!b_ready) begin
            @(posedge clk); #1; n++;
            if (n > 50) begin fail_now("b_ready_timeout"); break; end
        end
        regs[instr[25:21]] = va;
        regs[instr[20:16]] = vb;
        b_rd_value = rdv; b_pc = pcv; b_instr = instr; b_rv = 1'b1;
        @(posedge clk); #1;
        b_rv = 1'b0;
    endtask

    task automatic drain_b();
        int n;
        n = 0;
        while (!b_ready) begin
            @(posedge clk); #1; n++;
            if (n > 50) begin fail_now("b_drain_timeout"); break; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    logic [5:0]  fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [31:0] edge_vals [4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'h7FFF_FFFF};

    initial begin
        int          k, pulses0;
        logic [31:0] ins, va, vb;
        logic [5:0]  op, fn;
        for (int i = 0; i < 32; i++) regs[i] = '0;

        // reset both DUTs
        repeat (2) @(posedge clk);
        #1;
        check("a_rst_ready", a_ready, 1);
        check("a_rst_rs", a_rs, 0);
        check("a_rst_rt", a_rt, 0);
        check("a_rst_err", a_err, 0);
        check("a_rst_err_pc", a_err_pc, 0);
        check("a_rst_chk", a_chk, 0);
        check("a_rst_errc", a_errc, 0);
        check("a_rst_skip", a_skip, 0);
        a_rst = 1'b0; b_rst = 1'b0;
        mon_en = 1'b1;

        // directed: ADD match
        issue_a(mk_r(5, 6, 7, 6'h20), 32'h10, 32'h3, 1'b0, 32'h13, 32'h100, 0);
        drain_a();
        check("a_add_chk", a_chk, 1);
        check("a_add_errc", a_errc, 0);
        // SUB mismatch
        issue_a(mk_r(5, 6, 7, 6'h22), 32'h10, 32'h3, 1'b0, 32'hE, 32'h400, 0);
        drain_a();
        check("a_sub_errc", a_errc, 1);
        check("a_sub_err_pc", a_err_pc, 32'h400);
        // SLT signed, ADD wrap
        issue_a(mk_r(1, 2, 3, 6'h2A), 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h1, 32'h404, 0);
        issue_a(mk_r(1, 2, 3, 6'h20), 32'hFFFF_FFFF, 32'h2, 1'b0, 32'h1, 32'h408, 0);
        // rd = 0: expected value forced to zero
        issue_a(mk_r(1, 2, 0, 6'h20), 32'h5, 32'h6, 1'b0, 32'h0, 32'h40C, 0);
        issue_a(mk_r(1, 2, 0, 6'h20), 32'h5, 32'h6, 1'b0, 32'hB, 32'h410, 0);
        // unsupported lw, then retire_valid held through the busy cycles
        issue_a({6'h23, 5'd5, 5'd6, 16'h0004}, 32'h1, 32'h2, 1'b0, 32'h3, 32'h414, 0);
        issue_a(mk_r(8, 9, 10, 6'h25), 32'hF0, 32'h0F, 1'b1, 32'h0, 32'h418, 2);
        drain_a();
        check("a_dir_chk", a_chk, 7);
        check("a_dir_skip", a_skip, 1);
        check("a_dir_errc", a_errc, 2);

        // randomized
        for (int t = 0; t < 150; t++) begin
            op = ($urandom_range(0, 9) < 7) ? 6'h00 : 6'($urandom_range(1, 63));
            fn = ($urandom_range(0, 4) != 0) ? fns[$urandom_range(0, 4)] : 6'($urandom);
            ins = {op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), fn};
            va = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            vb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            issue_a(ins, va, vb, 1'($urandom_range(0, 1)), $urandom, $urandom & 32'hFFFF_FFFC,
                    ($urandom_range(0, 7) == 0) ? 2 : 0);
        end
        drain_a();
        check("a_total_chk", a_chk, exp_chk);
        check("a_total_errc", a_errc, exp_err);
        check("a_total_skip", a_skip, exp_skip);

        // ---- DUT B: latency with RESP_LAT=3 ----
        check("b_rst_ready", b_ready, 1);
        check("b_rst_chk", b_chk, 0);
        issue_b(mk_r(11, 12, 13, 6'h20), 32'h10, 32'h20, 32'h30, 32'h200);
        k = 1;
        while (b_chk == 0 && k < 12) begin @(posedge clk); #1; if (b_chk == 0) k++; end
        check("b_latency", k, 4);
        check("b_lat_errc", b_errc, 0);
        check("b_lat_ready", b_ready, 1);

        // reset while in WAIT abandons a mismatching check
        pulses0 = b_err_pulses;
        issue_b(mk_r(14, 15, 16, 6'h22), 32'h10, 32'h3, 32'hE, 32'h300);
        @(posedge clk); #1;
        b_rst = 1'b1;
        @(posedge clk); #1;
        b_rst = 1'b0;
        check("b_wait_rst_ready", b_ready, 1);
        check("b_wait_rst_chk", b_chk, 0);
        check("b_wait_rst_errc", b_errc, 0);
        check("b_wait_rst_skip", b_skip, 0);
        check("b_wait_rst_err_pc", b_err_pc, 0);
        repeat (8) @(posedge clk);
        #1;
        check("b_wait_rst_chk_later", b_chk, 0);
        check("b_wait_rst_no_err", b_err_pulses - pulses0, 0);

        // reset overrides a simultaneous retire
        b_instr = mk_r(14, 15, 16, 6'h22); b_rd_value = 32'hE;
        b_rst = 1'b1; b_rv = 1'b1;
        @(posedge clk); #1;
        b_rst = 1'b0; b_rv = 1'b0;
        check("b_rst_rv_ready", b_ready, 1);
        repeat (8) @(posedge clk);
        #1;
        check("b_rst_rv_chk", b_chk, 0);
        check("b_rst_rv_no_err", b_err_pulses - pulses0, 0);

        // saturation of 4-bit counters
        pulses0 = b_err_pulses;
        for (int i = 0; i < 18; i++)
            issue_b(mk_r(17, 18, 19, 6'h22), 32'h10, 32'h3, 32'hE, 32'h1000 + 32'(i) * 4);
        drain_b();
        @(posedge clk); #1;
        check("b_sat_errc", b_errc, 15);
        check("b_sat_chk", b_chk, 15);
        check("b_sat_err_pc", b_err_pc, 32'h1044);
        check("b_sat_pulses", b_err_pulses - pulses0, 18);
        for (int i = 0; i < 17; i++)
            issue_b({6'h23, 5'd1, 5'd2, 16'h0008}, 32'h0, 32'h0, 32'h0, 32'h2000);
        drain_b();
        @(posedge clk); #1;
        check("b_sat_skip", b_skip, 15);
        check("b_sat_chk_after_skip", b_chk, 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
